// File: rtl/mc_ramp.sv
// mc_ramp: slews two 5-bit motor codes toward their targets one magnitude step per ramp tick.
// Optional obstacle limiting of forward speed is compiled in with `define MC_OBSTACLE_LIMIT_EN.
module mc_ramp #(
    parameter int unsigned STEP_TICKS = 1_000_000,
    parameter logic [7:0]  SLOW_DIST  = 8'd60,
    parameter logic [7:0]  STOP_DIST  = 8'd20,
    parameter logic [3:0]  SLOW_CAP   = 4'd6
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [4:0] DESIRED_MC1,
    input  logic [4:0] DESIRED_MC2,
    input  logic [7:0] DISTANCE1,
    input  logic [7:0] DISTANCE2,
    output logic [4:0] OUT_MC1,
    output logic [4:0] OUT_MC2,
    output logic       SETTLED
);

    localparam int unsigned   CW   = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_TICKS - 1);
    localparam logic [4:0]    FWD_ZERO = 5'h10;

    typedef enum logic [1:0] {HOLD, ACCEL, DECEL, FLIP} ramp_mode_t;

    logic [4:0]    r_des1, r_des2;
    logic [4:0]    r_out1, r_out2;
    logic          r_settled;
    logic [CW-1:0] r_cnt;

    logic          w_tick;
    logic          w_stop, w_slow;
    logic [4:0]    w_eff1, w_eff2;
    logic [4:0]    w_next1, w_next2;
    logic          w_estop1, w_estop2;

    function automatic logic [4:0] f_eff(input logic [4:0] des, input logic stop,
                                         input logic slow);
        logic [4:0] eff;
        eff = des;
        if (des[4] && stop)
            eff = FWD_ZERO;
        else if (des[4] && slow && (des[3:0] > SLOW_CAP))
            eff = {1'b1, SLOW_CAP};
        return eff;
    endfunction

    function automatic logic [4:0] f_next(input logic [4:0] cur, input logic [4:0] eff,
                                          input logic tick, input logic estop);
        ramp_mode_t mode;
        logic [4:0] nxt;
        nxt = cur;
        if (cur == eff)
            mode = HOLD;
        else if (cur[4] != eff[4])
            mode = FLIP;
        else if (cur[3:0] < eff[3:0])
            mode = ACCEL;
        else
            mode = DECEL;
        // Emergency stop bypasses the ramp; otherwise move only on a tick.
        if (estop) begin
            nxt = FWD_ZERO;
        end else if (tick) begin
            case (mode)
                ACCEL:   nxt[3:0] = cur[3:0] + 4'd1;
                DECEL:   nxt[3:0] = cur[3:0] - 4'd1;
                FLIP: begin
                    if (cur[3:0] != 4'd0)
                        nxt[3:0] = cur[3:0] - 4'd1;
                    else
                        nxt[4] = eff[4];
                end
                default: nxt = cur;
            endcase
        end
        return nxt;
    endfunction

`ifdef MC_OBSTACLE_LIMIT_EN
    logic [7:0] r_dist1, r_dist2;
    logic [7:0] w_dmin;
    logic       w_dvalid;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dist1 <= '0;
            r_dist2 <= '0;
        end else begin
            r_dist1 <= DISTANCE1;
            r_dist2 <= DISTANCE2;
        end
    end

    // A zero distance means no echo, so it never takes part in the minimum.
    always_comb begin
        w_dvalid = (r_dist1 != '0) || (r_dist2 != '0);
        if (r_dist1 == '0)
            w_dmin = r_dist2;
        else if (r_dist2 == '0)
            w_dmin = r_dist1;
        else
            w_dmin = (r_dist1 < r_dist2) ? r_dist1 : r_dist2;
        w_stop = w_dvalid && (w_dmin < STOP_DIST);
        w_slow = w_dvalid && !w_stop && (w_dmin < SLOW_DIST);
    end
`else
    logic w_unused_dist;
    assign w_unused_dist = ^{DISTANCE1, DISTANCE2};
    assign w_stop = 1'b0;
    assign w_slow = 1'b0;
`endif

    assign w_tick = (r_cnt == LAST);

    always_comb begin
        w_eff1   = f_eff(r_des1, w_stop, w_slow);
        w_eff2   = f_eff(r_des2, w_stop, w_slow);
        w_estop1 = w_stop && w_eff1[4] && r_out1[4];
        w_estop2 = w_stop && w_eff2[4] && r_out2[4];
        w_next1  = f_next(r_out1, w_eff1, w_tick, w_estop1);
        w_next2  = f_next(r_out2, w_eff2, w_tick, w_estop2);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_des1    <= FWD_ZERO;
            r_des2    <= FWD_ZERO;
            r_out1    <= FWD_ZERO;
            r_out2    <= FWD_ZERO;
            r_settled <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_des1    <= DESIRED_MC1;
            r_des2    <= DESIRED_MC2;
            r_out1    <= w_next1;
            r_out2    <= w_next2;
            r_settled <= (r_out1 == w_eff1) && (r_out2 == w_eff2);
            r_cnt     <= w_tick ? '0 : r_cnt + 1'b1;
        end
    end

    assign OUT_MC1 = r_out1;
    assign OUT_MC2 = r_out2;
    assign SETTLED = r_settled;

endmodule
